// File: rtl/id_decode_stage_pkg.sv
// Decode-stage definitions: opcode constants, instruction field positions
// and the decoded-instruction record.
package idpkg;

    localparam int INSTR_W  = 21;
    localparam int OPC_HI   = 19;
    localparam int OPC_LO   = 15;
    localparam int RD_HI    = 14;
    localparam int RD_LO    = 10;
    localparam int RS1_HI   = 9;
    localparam int RS1_LO   = 5;
    localparam int RS2_HI   = 4;
    localparam int RS2_LO   = 0;
    localparam int IMM_HI   = 9;
    localparam int IMM_LO   = 0;
    localparam int IMM_W    = IMM_HI - IMM_LO + 1;
    localparam int FILE_BIT = 4;

    localparam logic [4:0] OPC_RS1ZERO = 5'b10111;

    typedef struct packed {
        logic [4:0] opcode;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } dec_instr_t;

    function automatic dec_instr_t decode_fields(input logic [INSTR_W-1:0] instr);
        dec_instr_t d;
        d.opcode = instr[OPC_HI:OPC_LO];
        d.rd     = instr[RD_HI:RD_LO];
        d.rs1    = instr[RS1_HI:RS1_LO];
        d.rs2    = instr[RS2_HI:RS2_LO];
        if (d.opcode == OPC_RS1ZERO) begin
            d.rs1 = '0;
        end
        return d;
    endfunction

endpackage

// File: rtl/id_regfile.sv
// Register file with two asynchronous read ports and one write port,
// cleared by synchronous reset.
module id_regfile #(
    parameter int WIDTH = 32,
    parameter int NREG  = 16,
    parameter int AW    = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr1,
    input  logic [AW-1:0]    i_raddr2,
    output logic [WIDTH-1:0] o_rdata1,
    output logic [WIDTH-1:0] o_rdata2
);

    logic [WIDTH-1:0] r_mem [NREG];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata1 = r_mem[i_raddr1];
    assign o_rdata2 = r_mem[i_raddr2];

endmodule

// File: rtl/id_decode_stage.sv
// Instruction decode stage: field decode, scalar/vector operand read with
// EX/MEM/writeback forwarding, load-use bubble and registered ID->EX output.
module id_decode_stage
    import idpkg::*;
#(
    parameter int XLEN    = 32,
    parameter int VLEN    = 128,
    parameter int NREG    = 16,
    parameter int PC_W    = 12,
    parameter int EQ_FULL = 0,
    parameter int AW      = $clog2(NREG)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [20:0]        in_instr,
    input  logic [PC_W-1:0]    in_pc,
    input  logic               flush,
    input  logic               wb_en,
    input  logic               wb_vec,
    input  logic [AW-1:0]      wb_addr,
    input  logic [VLEN-1:0]    wb_data,
    input  logic               ex_wr,
    input  logic               ex_vec,
    input  logic [4:0]         ex_rd,
    input  logic               ex_load,
    input  logic [VLEN-1:0]    ex_data,
    input  logic               mem_wr,
    input  logic               mem_vec,
    input  logic [4:0]         mem_rd,
    input  logic [VLEN-1:0]    mem_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [4:0]         out_opcode,
    output logic [4:0]         out_rd,
    output logic [4:0]         out_rs1,
    output logic [4:0]         out_rs2,
    output logic [VLEN-1:0]    out_data1,
    output logic [VLEN-1:0]    out_data2,
    output logic [XLEN-1:0]    out_imm,
    output logic [PC_W-1:0]    out_br_target,
    output logic               out_equal,
    output logic [15:0]        stall_cnt
);

    dec_instr_t      w_dec;
    logic [XLEN-1:0] w_s_rd1, w_s_rd2;
    logic [VLEN-1:0] w_v_rd1, w_v_rd2;
    logic [VLEN-1:0] w_op1, w_op2;
    logic [XLEN-1:0] w_imm;
    logic            w_equal, w_hazard, w_load, w_xfer;
    logic            w_unused_instr_msb;

    logic               r_out_valid, r_equal;
    logic [4:0]         r_opcode, r_rd, r_rs1, r_rs2;
    logic [VLEN-1:0]    r_data1, r_data2;
    logic [XLEN-1:0]    r_imm;
    logic [PC_W-1:0]    r_br_target;
    logic [15:0]        r_stall_cnt;

    assign w_dec              = decode_fields(in_instr);
    assign w_unused_instr_msb = in_instr[20];

    id_regfile #(.WIDTH(XLEN), .NREG(NREG)) u_sreg (
        .clk      (clk),
        .rst      (rst),
        .i_we     (wb_en && !wb_vec),
        .i_waddr  (wb_addr),
        .i_wdata  (wb_data[XLEN-1:0]),
        .i_raddr1 (w_dec.rs1[AW-1:0]),
        .i_raddr2 (w_dec.rs2[AW-1:0]),
        .o_rdata1 (w_s_rd1),
        .o_rdata2 (w_s_rd2)
    );

    id_regfile #(.WIDTH(VLEN), .NREG(NREG)) u_vreg (
        .clk      (clk),
        .rst      (rst),
        .i_we     (wb_en && wb_vec),
        .i_waddr  (wb_addr),
        .i_wdata  (wb_data),
        .i_raddr1 (w_dec.rs1[AW-1:0]),
        .i_raddr2 (w_dec.rs2[AW-1:0]),
        .o_rdata1 (w_v_rd1),
        .o_rdata2 (w_v_rd2)
    );

    // Specifier 0 is scalar zero: never forwarded, never a hazard source.
    function automatic logic [VLEN-1:0] pick_operand(input logic [4:0] rs,
                                                     input logic [XLEN-1:0] s_q,
                                                     input logic [VLEN-1:0] v_q);
        logic            is_vec;
        logic [VLEN-1:0] val;
        is_vec = rs[FILE_BIT];
        if (rs == 5'd0)
            val = '0;
        else if (ex_wr && (ex_vec == is_vec) && (ex_rd == rs))
            val = is_vec ? ex_data : VLEN'(ex_data[XLEN-1:0]);
        else if (mem_wr && (mem_vec == is_vec) && (mem_rd == rs))
            val = is_vec ? mem_data : VLEN'(mem_data[XLEN-1:0]);
        else if (wb_en && (wb_vec == is_vec) && (wb_addr == rs[AW-1:0]))
            val = is_vec ? wb_data : VLEN'(wb_data[XLEN-1:0]);
        else
            val = is_vec ? v_q : VLEN'(s_q);
        return val;
    endfunction

    function automatic logic load_use_hit(input logic [4:0] rs);
        return ex_wr && ex_load && (rs != 5'd0) && (ex_vec == rs[FILE_BIT]) && (ex_rd == rs);
    endfunction

    always_comb begin
        w_op1    = pick_operand(w_dec.rs1, w_s_rd1, w_v_rd1);
        w_op2    = pick_operand(w_dec.rs2, w_s_rd2, w_v_rd2);
        w_equal  = (EQ_FULL != 0) ? (w_op1 == w_op2) : (w_op1[XLEN-1:0] == w_op2[XLEN-1:0]);
        w_imm    = {{(XLEN-IMM_W){in_instr[IMM_HI]}}, in_instr[IMM_HI:IMM_LO]};
        w_hazard = in_valid && (load_use_hit(w_dec.rs1) || load_use_hit(w_dec.rs2));
        w_load   = !r_out_valid || out_ready;
        in_ready = !rst && w_load && !w_hazard;
        w_xfer   = in_valid && in_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_opcode    <= '0;
            r_rd        <= '0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_data1     <= '0;
            r_data2     <= '0;
            r_imm       <= '0;
            r_br_target <= '0;
            r_equal     <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            if (flush) begin
                r_out_valid <= 1'b0;
            end else if (w_load) begin
                r_out_valid <= w_xfer;
                if (w_xfer) begin
                    r_opcode    <= w_dec.opcode;
                    r_rd        <= w_dec.rd;
                    r_rs1       <= w_dec.rs1;
                    r_rs2       <= w_dec.rs2;
                    r_data1     <= w_op1;
                    r_data2     <= w_op2;
                    r_imm       <= w_imm;
                    r_br_target <= in_pc + w_imm[PC_W-1:0];
                    r_equal     <= w_equal;
                end
            end
            // Only bubbles actually issued into EX are counted.
            if (!flush && w_load && w_hazard && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

    assign out_valid     = r_out_valid;
    assign out_opcode    = r_opcode;
    assign out_rd        = r_rd;
    assign out_rs1       = r_rs1;
    assign out_rs2       = r_rs2;
    assign out_data1     = r_data1;
    assign out_data2     = r_data2;
    assign out_imm       = r_imm;
    assign out_br_target = r_br_target;
    assign out_equal     = r_equal;
    assign stall_cnt     = r_stall_cnt;

endmodule

// File: tb/tb_id_decode_stage.sv
// Scoreboard bench for id_decode_stage: directed cases, randomized traffic
// and stall counter saturation, checked against a register-level model.
module tb_id_decode_stage;

    localparam int XLEN = 32;
    localparam int VLEN = 128;
    localparam int NREG = 16;
    localparam int PC_W = 12;
    localparam int AW   = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst, in_valid, in_ready, flush;
    logic [20:0]     in_instr;
    logic [PC_W-1:0] in_pc;
    logic            wb_en, wb_vec;
    logic [AW-1:0]   wb_addr;
    logic [VLEN-1:0] wb_data;
    logic            ex_wr, ex_vec, ex_load;
    logic [4:0]      ex_rd;
    logic [VLEN-1:0] ex_data;
    logic            mem_wr, mem_vec;
    logic [4:0]      mem_rd;
    logic [VLEN-1:0] mem_data;
    logic            out_valid, out_ready, out_equal;
    logic [4:0]      out_opcode, out_rd, out_rs1, out_rs2;
    logic [VLEN-1:0] out_data1, out_data2;
    logic [XLEN-1:0] out_imm;
    logic [PC_W-1:0] out_br_target;
    logic [15:0]     stall_cnt;

    id_decode_stage #(.XLEN(XLEN), .VLEN(VLEN), .NREG(NREG), .PC_W(PC_W), .EQ_FULL(0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
        .wb_en(wb_en), .wb_vec(wb_vec), .wb_addr(wb_addr), .wb_data(wb_data),
        .ex_wr(ex_wr), .ex_vec(ex_vec), .ex_rd(ex_rd), .ex_load(ex_load), .ex_data(ex_data),
        .mem_wr(mem_wr), .mem_vec(mem_vec), .mem_rd(mem_rd), .mem_data(mem_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_opcode(out_opcode), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_data1(out_data1), .out_data2(out_data2), .out_imm(out_imm),
        .out_br_target(out_br_target), .out_equal(out_equal), .stall_cnt(stall_cnt)
    );

    typedef struct {
        logic [4:0]   opc, rd, rs1, rs2;
        logic [127:0] d1, d2;
        logic [31:0]  imm;
        logic [11:0]  bt;
        logic         eq;
    } exp_t;

    exp_t         sb[$];
    logic [31:0]  m_s [16];
    logic [127:0] m_v [16];
    bit           m_valid;
    int           m_stall;
    int           n_vec = 0;
    int           n_err = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [4:0] rand_spec();
        logic [4:0] s;
        s = 5'($urandom_range(0, 3));
        if ($urandom_range(0, 1) == 1) s[4] = 1'b1;
        return s;
    endfunction

    // Value an instruction should see for register specifier rs this cycle.
    function automatic logic [127:0] model_operand(input logic [4:0] rs);
        bit vec;
        vec = rs[4];
        if (rs == 5'd0) return '0;
        if (ex_wr && ex_vec == vec && ex_rd == rs)
            return vec ? ex_data : {96'd0, ex_data[31:0]};
        if (mem_wr && mem_vec == vec && mem_rd == rs)
            return vec ? mem_data : {96'd0, mem_data[31:0]};
        if (wb_en && wb_vec == vec && wb_addr == rs[3:0])
            return vec ? wb_data : {96'd0, wb_data[31:0]};
        return vec ? m_v[rs[3:0]] : {96'd0, m_s[rs[3:0]]};
    endfunction

    function automatic bit model_load_use(input logic [4:0] rs);
        return rs != 5'd0 && ex_wr && ex_load && ex_vec == rs[4] && ex_rd == rs;
    endfunction

    task automatic idle_inputs();
        in_valid = 0; in_instr = '0; in_pc = '0; flush = 0; out_ready = 1;
        wb_en = 0; wb_vec = 0; wb_addr = '0; wb_data = '0;
        ex_wr = 0; ex_vec = 0; ex_rd = '0; ex_load = 0; ex_data = '0;
        mem_wr = 0; mem_vec = 0; mem_rd = '0; mem_data = '0;
    endtask

    // One clock: predict the edge from current inputs, then advance past it.
    task automatic step();
        logic [4:0]        rs1, rs2;
        logic signed [9:0] i10;
        int                iv;
        bit                hz, loadable, rdy, acc;
        exp_t              e;
        @(negedge clk);
        #1;
        rs1 = (in_instr[19:15] == 5'b10111) ? 5'd0 : in_instr[9:5];
        rs2 = in_instr[4:0];
        hz = in_valid && (model_load_use(rs1) || model_load_use(rs2));
        loadable = !m_valid || out_ready;
        rdy = loadable && !hz;
        acc = in_valid && rdy;
        chk("in_ready", 128'(in_ready), 128'(rdy));
        chk("out_valid", 128'(out_valid), 128'(m_valid));
        chk("stall_cnt", 128'(stall_cnt), 128'(m_stall));
        if (flush) begin
            if (m_valid && !out_ready && sb.size() > 0) void'(sb.pop_front());
            m_valid = 0;
        end else if (loadable) begin
            if (hz && m_stall < 65535) m_stall++;
            if (acc) begin
                i10   = in_instr[9:0];
                iv    = i10;
                e.opc = in_instr[19:15];
                e.rd  = in_instr[14:10];
                e.rs1 = rs1;
                e.rs2 = rs2;
                e.d1  = model_operand(rs1);
                e.d2  = model_operand(rs2);
                e.imm = 32'(iv);
                e.bt  = 12'((int'(in_pc) + iv) & 32'hFFF);
                e.eq  = (e.d1[31:0] == e.d2[31:0]);
                sb.push_back(e);
            end
            m_valid = acc;
        end
        if (wb_en) begin
            if (wb_vec) m_v[wb_addr] = wb_data;
            else        m_s[wb_addr] = wb_data[31:0];
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 128'(in_ready), 128'(0));
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_stall", 128'(stall_cnt), 128'(0));
        chk("rst_data1", out_data1, 128'(0));
        chk("rst_imm", 128'(out_imm), 128'(0));
        chk("rst_br", 128'(out_br_target), 128'(0));
        @(posedge clk);
        #1;
        rst = 0;
        for (int i = 0; i < 16; i++) begin
            m_s[i] = '0;
            m_v[i] = '0;
        end
        m_valid = 0;
        m_stall = 0;
        sb.delete();
    endtask

    task automatic set_instr(input logic [4:0] opc, input logic [4:0] rd,
                             input logic [4:0] rs1, input logic [4:0] rs2);
        in_instr = {1'b0, opc, rd, rs1, rs2};
    endtask

    task automatic rand_inputs();
        logic [4:0] opc;
        opc = ($urandom_range(0, 3) == 0) ? 5'b10111 : 5'($urandom_range(0, 31));
        in_valid = ($urandom_range(0, 3) != 0);
        set_instr(opc, 5'($urandom), rand_spec(), rand_spec());
        if ($urandom_range(0, 3) == 0) in_instr[9:0] = 10'($urandom);
        in_instr[20] = 1'($urandom_range(0, 1));
        in_pc     = 12'($urandom);
        out_ready = ($urandom_range(0, 3) != 0);
        flush     = ($urandom_range(0, 19) == 0);
        wb_en     = 1'($urandom_range(0, 1));
        wb_vec    = 1'($urandom_range(0, 1));
        wb_addr   = 4'($urandom_range(0, 3));
        wb_data   = rand128();
        ex_wr     = 1'($urandom_range(0, 1));
        ex_rd     = rand_spec();
        ex_vec    = ex_rd[4];
        ex_load   = ($urandom_range(0, 2) == 0);
        ex_data   = rand128();
        mem_wr    = 1'($urandom_range(0, 1));
        mem_rd    = rand_spec();
        mem_vec   = mem_rd[4];
        mem_data  = rand128();
    endtask

    // Monitor: every presented output must match the oldest outstanding entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid) begin
                if (sb.size() == 0) begin
                    chk("sb_empty_out_valid", 128'(out_valid), 128'(0));
                end else begin
                    e = sb[0];
                    chk("opcode", 128'(out_opcode), 128'(e.opc));
                    chk("rd", 128'(out_rd), 128'(e.rd));
                    chk("rs1", 128'(out_rs1), 128'(e.rs1));
                    chk("rs2", 128'(out_rs2), 128'(e.rs2));
                    chk("data1", out_data1, e.d1);
                    chk("data2", out_data2, e.d2);
                    chk("imm", 128'(out_imm), 128'(e.imm));
                    chk("br_target", 128'(out_br_target), 128'(e.bt));
                    chk("equal", 128'(out_equal), 128'(e.eq));
                    if (out_ready) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        // load-use on s4: one bubble, then the value arrives from MEM
        ex_wr = 1; ex_vec = 0; ex_rd = 5'd4; ex_load = 1; ex_data = rand128();
        in_valid = 1; set_instr(5'd0, 5'd1, 5'd4, 5'd0);
        step();
        chk("t_loaduse_bubble", 128'(out_valid), 128'(0));
        chk("t_loaduse_stall", 128'(stall_cnt), 128'(1));
        ex_wr = 0; ex_load = 0;
        mem_wr = 1; mem_vec = 0; mem_rd = 5'd4; mem_data = 128'h1234_5678;
        step();
        chk("t_loaduse_valid", 128'(out_valid), 128'(1));
        chk("t_loaduse_memfwd", out_data1, 128'h1234_5678);
        in_valid = 0; mem_wr = 0;
        step();

        // writeback s3 = 5, then read s3, s3
        wb_en = 1; wb_vec = 0; wb_addr = 4'd3; wb_data = 128'h5;
        step();
        wb_en = 0; in_valid = 1; set_instr(5'd2, 5'd6, 5'd3, 5'd3);
        step();
        chk("t_wb_data1", out_data1, 128'h5);
        chk("t_wb_data2", out_data2, 128'h5);
        chk("t_wb_equal", 128'(out_equal), 128'(1));

        // same-cycle writeback of s7 is bypassed to the reader
        wb_en = 1; wb_addr = 4'd7; wb_data = 128'h77;
        set_instr(5'd3, 5'd2, 5'd7, 5'b10000);
        step();
        chk("t_bypass_data1", out_data1, 128'h77);
        wb_en = 0; in_valid = 0;
        step();

        // EX beats MEM on v2
        ex_wr = 1; ex_vec = 1; ex_rd = 5'b10010; ex_load = 0; ex_data = {4{32'hAAAA_AAAA}};
        mem_wr = 1; mem_vec = 1; mem_rd = 5'b10010; mem_data = {4{32'h5555_5555}};
        in_valid = 1; set_instr(5'd4, 5'd3, 5'b10010, 5'd0);
        step();
        chk("t_exwins_data1", out_data1, {4{32'hAAAA_AAAA}});
        ex_wr = 0; mem_wr = 0; in_valid = 0;
        step();

        // branch target wraps in both directions
        in_valid = 1; in_pc = 12'hFFE; in_instr = {1'b0, 5'd5, 5'd1, 10'h004};
        step();
        chk("t_br_wrap_up", 128'(out_br_target), 128'(12'h002));
        chk("t_imm_pos", 128'(out_imm), 128'(32'h4));
        in_pc = 12'h001; in_instr = {1'b0, 5'd6, 5'd9, 10'h3FE};
        step();
        chk("t_br_wrap_down", 128'(out_br_target), 128'(12'hFFF));

        // backpressure for three cycles, then flush
        out_ready = 0; in_pc = 12'h100; set_instr(5'd7, 5'd11, 5'd1, 5'd2);
        repeat (3) step();
        chk("t_hold_valid", 128'(out_valid), 128'(1));
        chk("t_hold_imm", 128'(out_imm), 128'(32'hFFFF_FFFE));
        chk("t_hold_rd", 128'(out_rd), 128'(5'd9));
        flush = 1;
        step();
        chk("t_flush_valid", 128'(out_valid), 128'(0));
        flush = 0; in_valid = 0; out_ready = 1;
        step();

        repeat (3000) begin
            rand_inputs();
            step();
        end

        // reset mid-traffic clears the files and any held instruction
        do_reset();
        repeat (300) begin
            rand_inputs();
            step();
        end

        // stall counter saturation
        do_reset();
        ex_wr = 1; ex_vec = 1; ex_rd = 5'b10001; ex_load = 1;
        in_valid = 1; set_instr(5'd1, 5'd1, 5'b10001, 5'd0);
        repeat (65540) step();
        chk("t_stall_sat", 128'(stall_cnt), 128'(16'hFFFF));
        idle_inputs();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
